// File: rtl/axi_aw_arbiter.sv
// axi_aw_arbiter: round-robin AW arbiter for one AXI4 master port.
// Ports: clk, rst_n (async, active-low); per-slave aw*_i/awvalid_i/awready_o;
// master aw*_o/awvalid_o/awready_i; push_ID_o/ID_o to the write-data
// allocator ID FIFO, grant_FIFO_ID_i = ID FIFO not full.
// Option: AXI_AW_ARB_OUT_REG_EN inserts a one-entry output register.
module axi_aw_arbiter #(
  parameter int AXI_ID_W      = 4,
  parameter int AXI_ADDRESS_W = 32,
  parameter int AXI_USER_W    = 6,
  parameter int N_TARG_PORT   = 7,
  parameter int LOG_N_TARG    = $clog2(N_TARG_PORT)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [N_TARG_PORT-1:0][AXI_ID_W-1:0]      awid_i,
  input  logic [N_TARG_PORT-1:0][AXI_ADDRESS_W-1:0] awaddr_i,
  input  logic [N_TARG_PORT-1:0][7:0]               awlen_i,
  input  logic [N_TARG_PORT-1:0][2:0]               awsize_i,
  input  logic [N_TARG_PORT-1:0][1:0]               awburst_i,
  input  logic [N_TARG_PORT-1:0]                    awlock_i,
  input  logic [N_TARG_PORT-1:0][3:0]               awcache_i,
  input  logic [N_TARG_PORT-1:0][2:0]               awprot_i,
  input  logic [N_TARG_PORT-1:0][3:0]               awregion_i,
  input  logic [N_TARG_PORT-1:0][AXI_USER_W-1:0]    awuser_i,
  input  logic [N_TARG_PORT-1:0][3:0]               awqos_i,
  input  logic [N_TARG_PORT-1:0]                    awvalid_i,
  output logic [N_TARG_PORT-1:0]                    awready_o,
  output logic [AXI_ID_W-1:0]                       awid_o,
  output logic [AXI_ADDRESS_W-1:0]                  awaddr_o,
  output logic [7:0]                                awlen_o,
  output logic [2:0]                                awsize_o,
  output logic [1:0]                                awburst_o,
  output logic                                      awlock_o,
  output logic [3:0]                                awcache_o,
  output logic [2:0]                                awprot_o,
  output logic [3:0]                                awregion_o,
  output logic [AXI_USER_W-1:0]                     awuser_o,
  output logic [3:0]                                awqos_o,
  output logic                                      awvalid_o,
  input  logic                                      awready_i,
  output logic                                      push_ID_o,
  output logic [LOG_N_TARG+N_TARG_PORT-1:0]         ID_o,
  input  logic                                      grant_FIFO_ID_i
);

  localparam int PW = AXI_ID_W + AXI_ADDRESS_W + 8 + 3 + 2 + 1
                    + 4 + 3 + 4 + AXI_USER_W + 4;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t                  state_q, state_d;
  logic [LOG_N_TARG-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LOG_N_TARG-1:0]   lock_idx_q, lock_idx_d;
  logic [LOG_N_TARG-1:0]   rr_win, win, cand;
  logic                    found;
  logic                    any_valid;
  logic [N_TARG_PORT-1:0]  win_oh;
  logic [PW-1:0]           pay [N_TARG_PORT];
  logic [PW-1:0]           mux_pay, out_pay;
  logic                    hs, stall;

  function automatic logic [LOG_N_TARG-1:0] wrap_inc(
    input logic [LOG_N_TARG-1:0] a
  );
    return (int'(a) == N_TARG_PORT-1) ? '0 : a + 1'b1;
  endfunction

  always_comb begin
    for (int p = 0; p < N_TARG_PORT; p++) begin
      pay[p] = {awid_i[p], awaddr_i[p], awlen_i[p],
                awsize_i[p], awburst_i[p], awlock_i[p],
                awcache_i[p], awprot_i[p], awregion_i[p],
                awuser_i[p], awqos_i[p]};
    end
  end

  assign any_valid = |awvalid_i;

  // search upward from rr_ptr, wrapping at N_TARG_PORT
  always_comb begin
    rr_win = rr_ptr_q;
    found  = 1'b0;
    cand   = rr_ptr_q;
    for (int i = 0; i < N_TARG_PORT; i++) begin
      if (!found && awvalid_i[cand]) begin
        found  = 1'b1;
        rr_win = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_idx_q <= '0;
      rr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      lock_idx_q <= lock_idx_d;
      rr_ptr_q   <= rr_ptr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    lock_idx_d = lock_idx_q;
    unique case (state_q)
      IDLE: begin
        if (stall) begin
          state_d    = LOCKED;
          lock_idx_d = rr_win;
        end
      end
      LOCKED: begin
        if (hs) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    win    = (state_q == LOCKED) ? lock_idx_q : rr_win;
    win_oh = '0;
    if (any_valid) win_oh[win] = 1'b1;
    mux_pay  = any_valid ? pay[win] : '0;
    rr_ptr_d = hs ? wrap_inc(win) : rr_ptr_q;
  end

  assign ID_o = {win, win_oh};

`ifdef AXI_AW_ARB_OUT_REG_EN
  logic          reg_valid_q;
  logic [PW-1:0] reg_pay_q;
  logic          reg_ready;

  // register takes a new beat when empty or drained this cycle
  assign reg_ready = !reg_valid_q || awready_i;
  assign hs        = any_valid && grant_FIFO_ID_i && reg_ready;
  assign stall     = 1'b0;
  assign awready_o = win_oh & {N_TARG_PORT{reg_ready && grant_FIFO_ID_i}};
  assign push_ID_o = hs;
  assign awvalid_o = reg_valid_q;
  assign out_pay   = reg_pay_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_valid_q <= 1'b0;
      reg_pay_q   <= '0;
    end else if (hs) begin
      reg_valid_q <= 1'b1;
      reg_pay_q   <= mux_pay;
    end else if (awready_i) begin
      reg_valid_q <= 1'b0;
    end
  end
`else
  logic up_valid;

  assign up_valid  = any_valid && grant_FIFO_ID_i;
  assign hs        = up_valid && awready_i;
  assign stall     = up_valid && !awready_i;
  assign awready_o = win_oh & {N_TARG_PORT{awready_i && grant_FIFO_ID_i}};
  assign push_ID_o = hs;
  assign awvalid_o = up_valid;
  assign out_pay   = mux_pay;
`endif

  assign {awid_o, awaddr_o, awlen_o, awsize_o, awburst_o, awlock_o,
          awcache_o, awprot_o, awregion_o, awuser_o, awqos_o} = out_pay;

endmodule

// File: tb/tb_axi_aw_arbiter.sv
// tb_axi_aw_arbiter: directed bench for axi_aw_arbiter (N_TARG_PORT=4)
// with an in-bench arbitration model checked on every falling edge.
module tb_axi_aw_arbiter;

  localparam int N  = 4;
  localparam int IW = 4;
  localparam int AW = 32;
  localparam int UW = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0][IW-1:0] awid_i;
  logic [N-1:0][AW-1:0] awaddr_i;
  logic [N-1:0][7:0]    awlen_i;
  logic [N-1:0][2:0]    awsize_i;
  logic [N-1:0][1:0]    awburst_i;
  logic [N-1:0]         awlock_i;
  logic [N-1:0][3:0]    awcache_i;
  logic [N-1:0][2:0]    awprot_i;
  logic [N-1:0][3:0]    awregion_i;
  logic [N-1:0][UW-1:0] awuser_i;
  logic [N-1:0][3:0]    awqos_i;
  logic [N-1:0]         awvalid_i;
  logic [N-1:0]         awready_o;
  logic [IW-1:0]        awid_o;
  logic [AW-1:0]        awaddr_o;
  logic [7:0]           awlen_o;
  logic [2:0]           awsize_o;
  logic [1:0]           awburst_o;
  logic                 awlock_o;
  logic [3:0]           awcache_o;
  logic [2:0]           awprot_o;
  logic [3:0]           awregion_o;
  logic [UW-1:0]        awuser_o;
  logic [3:0]           awqos_o;
  logic                 awvalid_o;
  logic                 awready_i;
  logic                 push_ID_o;
  logic [5:0]           ID_o;
  logic                 grant_FIFO_ID_i;

  axi_aw_arbiter #(
    .AXI_ID_W(IW), .AXI_ADDRESS_W(AW), .AXI_USER_W(UW), .N_TARG_PORT(N)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .awid_i(awid_i), .awaddr_i(awaddr_i), .awlen_i(awlen_i),
    .awsize_i(awsize_i), .awburst_i(awburst_i), .awlock_i(awlock_i),
    .awcache_i(awcache_i), .awprot_i(awprot_i), .awregion_i(awregion_i),
    .awuser_i(awuser_i), .awqos_i(awqos_i),
    .awvalid_i(awvalid_i), .awready_o(awready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awsize_o(awsize_o), .awburst_o(awburst_o), .awlock_o(awlock_o),
    .awcache_o(awcache_o), .awprot_o(awprot_o), .awregion_o(awregion_o),
    .awuser_o(awuser_o), .awqos_o(awqos_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .push_ID_o(push_ID_o), .ID_o(ID_o),
    .grant_FIFO_ID_i(grant_FIFO_ID_i)
  );

  int checks = 0;
  int failures = 0;

  int          m_ptr  = 0;
  int          m_held = -1;
  bit          m_rv   = 1'b0;
  logic [31:0] m_ra   = '0;
  logic [5:0]  push_log [$];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  function automatic int pick();
    if (m_held >= 0) return m_held;
    for (int i = 0; i < N; i++)
      if (awvalid_i[(m_ptr + i) % N]) return (m_ptr + i) % N;
    return -1;
  endfunction

  function automatic logic [5:0] id_of(input int w);
    return 6'((w << 4) | (1 << w));
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_ptr = 0; m_held = -1; m_rv = 1'b0;
        chk("rst_awvalid", 64'(awvalid_o), 0);
        chk("rst_awready", 64'(awready_o), 0);
        chk("rst_push", 64'(push_ID_o), 0);
        chk("rst_awaddr", 64'(awaddr_o), 0);
      end else begin
        int   w;
        bit   any, up;
        logic [3:0] er;
        w   = pick();
        any = |awvalid_i;
`ifdef AXI_AW_ARB_OUT_REG_EN
        chk("awvalid", 64'(awvalid_o), 64'(m_rv));
        if (m_rv) chk("awaddr", 64'(awaddr_o), 64'(m_ra));
        up = any && grant_FIFO_ID_i && (!m_rv || awready_i);
`else
        up = any && grant_FIFO_ID_i && awready_i;
        chk("awvalid", 64'(awvalid_o), 64'(any && grant_FIFO_ID_i));
        if (any && grant_FIFO_ID_i) begin
          chk("awaddr", 64'(awaddr_o), 64'(awaddr_i[w]));
          chk("awlen", 64'(awlen_o), 64'(awlen_i[w]));
        end
`endif
        er = up ? 4'(1 << w) : 4'b0;
        chk("awready", 64'(awready_o), 64'(er));
        chk("push", 64'(push_ID_o), 64'(up));
        if (up) chk("id", 64'(ID_o), 64'(id_of(w)));
        if (push_ID_o) push_log.push_back(ID_o);
`ifdef AXI_AW_ARB_OUT_REG_EN
        if (up) begin
          m_rv = 1'b1; m_ra = awaddr_i[w]; m_ptr = (w + 1) % N;
        end else if (awready_i) begin
          m_rv = 1'b0;
        end
`else
        if (up) begin
          m_ptr = (w + 1) % N; m_held = -1;
        end else if (any && grant_FIFO_ID_i) begin
          m_held = w;
        end
`endif
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] exp2 [5];
    exp2 = '{6'h01, 6'h12, 6'h24, 6'h38, 6'h01};
    for (int p = 0; p < N; p++) begin
      awid_i[p]     = IW'(p);
      awaddr_i[p]   = 32'h1000_0000 + 32'(p * 256);
      awlen_i[p]    = 8'(p + 1);
      awsize_i[p]   = 3'(p);
      awburst_i[p]  = 2'b01;
      awlock_i[p]   = 1'b0;
      awcache_i[p]  = 4'(p);
      awprot_i[p]   = 3'(p);
      awregion_i[p] = 4'(p);
      awuser_i[p]   = UW'(p + 3);
      awqos_i[p]    = 4'(p);
    end
    awvalid_i = '0;
    awready_i = 1'b0;
    grant_FIFO_ID_i = 1'b1;
    rst_n = 1'b0;
    step(3);
    rst_n = 1'b1;

    push_log.delete();
    step(10);
    chk("idle_pushes", 64'(push_log.size()), 0);

`ifdef AXI_AW_ARB_OUT_REG_EN
    awvalid_i = 4'b0011;
    awready_i = 1'b1;
    push_log.delete();
    #1;
    chk("reg_lat0", 64'(awvalid_o), 0);
    step(1);
    chk("reg_lat1", 64'(awvalid_o), 1);
    step(3);
    awvalid_i = '0;
    chk("reg_pushes", 64'(push_log.size()), 4);
    chk("reg_id0", 64'(push_log[0]), 64'h01);
    chk("reg_id1", 64'(push_log[1]), 64'h12);
    chk("reg_id2", 64'(push_log[2]), 64'h01);
    chk("reg_id3", 64'(push_log[3]), 64'h12);
    step(3);
`else
    awvalid_i = 4'hF;
    awready_i = 1'b1;
    push_log.delete();
    step(5);
    awvalid_i = '0;
    chk("rr_pushes", 64'(push_log.size()), 5);
    for (int i = 0; i < 5; i++)
      if (i < push_log.size())
        chk($sformatf("rr_id%0d", i), 64'(push_log[i]), 64'(exp2[i]));

    awready_i = 1'b0;
    awvalid_i = 4'b0100;
    step(1);
    awvalid_i = 4'b0101;
    step(5);
    chk("lock_addr", 64'(awaddr_o), 64'h1000_0200);
    chk("lock_valid", 64'(awvalid_o), 1);
    chk("lock_ready", 64'(awready_o), 0);
    push_log.delete();
    awready_i = 1'b1;
    #1;
    chk("lock_grant", 64'(awready_o), 64'b0100);
    step(1);
    awvalid_i = '0;
    awready_i = 1'b0;
    chk("lock_pushes", 64'(push_log.size()), 1);
    chk("lock_id", 64'(push_log[0]), 64'h24);

    awvalid_i = 4'b0010;
    awready_i = 1'b1;
    grant_FIFO_ID_i = 1'b0;
    push_log.delete();
    step(3);
    chk("full_valid", 64'(awvalid_o), 0);
    chk("full_ready", 64'(awready_o), 0);
    chk("full_pushes", 64'(push_log.size()), 0);
    grant_FIFO_ID_i = 1'b1;
    step(1);
    awvalid_i = '0;
    chk("full_rel_pushes", 64'(push_log.size()), 1);
    chk("full_rel_id", 64'(push_log[0]), 64'h12);

    awvalid_i = 4'b1000;
    push_log.delete();
    step(3);
    awvalid_i = '0;
    chk("wrap_pushes", 64'(push_log.size()), 3);
    for (int i = 0; i < 3; i++)
      if (i < push_log.size())
        chk($sformatf("wrap_id%0d", i), 64'(push_log[i]), 64'h38);
    awvalid_i = 4'hF;
    push_log.delete();
    step(1);
    awvalid_i = '0;
    chk("wrap_next", 64'(push_log[0]), 64'h01);

    awready_i = 1'b0;
    awvalid_i = 4'b0100;
    step(2);
    rst_n = 1'b0;
    awvalid_i = '0;
    step(2);
    rst_n = 1'b1;
    awvalid_i = 4'b0101;
    awready_i = 1'b1;
    push_log.delete();
    step(1);
    awvalid_i = '0;
    chk("midrst_id", 64'(push_log[0]), 64'h01);
    step(2);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
